// File: rtl/nihilist_pkg.sv
// ============================================================================
// Module      : nihilist_pkg
// Description : Shared constants and helpers for the Nihilist/Polybius
//               encryptor: 5x5 table, fixed key, cipher byte type and the
//               character-to-code function.
//               Optional feature macro: NIHILIST_LOWERCASE_EN (fold 'a'..'z'
//               to uppercase before lookup).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nihilist_pkg;

    typedef logic [7:0] cipher_t;

    // Table rows are RAESB / CDFGH / IKLMN / OPQTU / VWXYZ; first char at MSB.
    localparam logic [8*25-1:0] POLYBIUS_TABLE = "RAESBCDFGHIKLMNOPQTUVWXYZ";

    // Fixed key shared with the decryptor.
    localparam int              KEY_LEN = 7;
    localparam logic [8*7-1:0]  KEY_STR = "NEDELCU";

    localparam cipher_t         ERR_CODE = 8'd0;

    // Returns {valid, row*10+col}; 'J' shares the 'I' cell.
    function automatic logic [8:0] polybius_code(input logic [7:0] ch);
        logic [7:0] up_ch;
        logic [8:0] res;
        up_ch = ch;
`ifdef NIHILIST_LOWERCASE_EN
        if (up_ch >= 8'h61 && up_ch <= 8'h7A) begin
            up_ch = up_ch - 8'h20;
        end
`endif
        if (up_ch == 8'h4A) begin
            up_ch = 8'h49;
        end
        res = {1'b0, ERR_CODE};
        for (int i = 0; i < 25; i++) begin
            if (up_ch == POLYBIUS_TABLE[8*(24-i) +: 8]) begin
                res = {1'b1, 8'(((i / 5) + 1) * 10 + (i % 5) + 1)};
            end
        end
        return res;
    endfunction

    // Key character at position idx, wrapping on the key length.
    function automatic logic [7:0] key_char(input logic [31:0] idx);
        int j;
        j = int'(idx % 32'(KEY_LEN));
        return KEY_STR[8*(KEY_LEN-1-j) +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/nihilist_encryptor_stream_polybius_lookup.sv
// ============================================================================
// Module      : polybius_lookup
// Description : Combinational character-to-Polybius-code lookup.
//               Optional feature macro: NIHILIST_LOWERCASE_EN (via package).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module polybius_lookup
    import nihilist_pkg::*;
(
    input  logic [7:0] ch,
    output cipher_t    code,
    output logic       valid
);

    logic [8:0] w_res;

    // Pure table lookup; invalid characters yield ERR_CODE with valid low.
    always_comb begin
        w_res = polybius_code(ch);
        valid = w_res[8];
        code  = w_res[7:0];
    end

endmodule

`default_nettype wire

// File: rtl/nihilist_encryptor_stream.sv
// ============================================================================
// Module      : nihilist_encryptor_stream
// Description : Byte-serial Nihilist/Polybius encryptor with valid/ready
//               handshakes and a two-stage pipeline. Each plaintext letter
//               produces code(plain) + code(key[k]).
//               Optional feature macro: NIHILIST_LOWERCASE_EN (lowercase
//               letters accepted and folded to uppercase).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nihilist_encryptor_stream
    import nihilist_pkg::*;
#(
    parameter int SEC_LEN = 7,
    parameter int KIDX_W  = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_err,
    output logic       busy
);

    logic [KIDX_W-1:0] r_k;
    logic              r_s1_valid;
    logic [7:0]        r_s1_data;
    logic              r_s1_last;
    logic [KIDX_W-1:0] r_s1_k;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_accept;
    logic [7:0]        w_key_char;
    cipher_t           w_plain_code;
    cipher_t           w_key_code;
    logic              w_plain_valid;
    logic              w_key_valid;

    // Handshake and stall control; no skid buffer, so ready is combinational.
    always_comb begin
        w_s2_adv   = !out_valid || out_ready;
        w_s1_adv   = w_s2_adv || !r_s1_valid;
        in_ready   = !r_s1_valid || w_s2_adv;
        w_accept   = in_valid && in_ready;
        w_key_char = key_char(32'(r_s1_k));
        busy       = r_s1_valid | out_valid;
    end

    polybius_lookup u_plain_lookup (
        .ch    (r_s1_data),
        .code  (w_plain_code),
        .valid (w_plain_valid)
    );

    polybius_lookup u_key_lookup (
        .ch    (w_key_char),
        .code  (w_key_code),
        .valid (w_key_valid)
    );

    // Key index: advances on every accepted byte (errors included) and
    // restarts at 0 after a message's last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
        end else if (w_accept) begin
            if (in_last || (r_k == KIDX_W'(SEC_LEN - 1))) begin
                r_k <= '0;
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    // Stage 1: capture the character together with the key index it uses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 8'd0;
            r_s1_last  <= 1'b0;
            r_s1_k     <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_data <= in_data;
                r_s1_last <= in_last;
                r_s1_k    <= r_k;
            end
        end
    end

    // Stage 2: add the two codes and present the result; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= ERR_CODE;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_last <= r_s1_last;
                if (w_plain_valid && w_key_valid) begin
                    out_data <= w_plain_code + w_key_code;
                    out_err  <= 1'b0;
                end else begin
                    out_data <= ERR_CODE;
                    out_err  <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nihilist_encryptor_stream.sv
// ============================================================================
// Module      : tb_nihilist_encryptor_stream
// Description : Directed self-checking bench for nihilist_encryptor_stream.
//               Optional feature macro: NIHILIST_LOWERCASE_EN changes the
//               expectation for lowercase input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nihilist_encryptor_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Captured output beats: {err, last, data}
    logic [9:0] r_q[$];

    nihilist_encryptor_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output transfer.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            r_q.push_back({out_err, out_last, out_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] c, input logic last);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_data  = c;
        in_last  = last;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 50) begin
            #4;
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Pop the next output beat (bounded wait) and compare all fields.
    task automatic expect_out(input string tag, input logic [7:0] d,
                              input logic last, input logic err);
        int n;
        n = 0;
        while (r_q.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (r_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk(tag, 32'(r_q.pop_front()), 32'({err, last, d}));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // HELLO with latency check: H accepted, one edge later S1 only,
        // after the next edge the result appears.
        send("H", 1'b0);
        chk("lat_after_s1", 32'(out_valid), 32'd0);
        send("E", 1'b0);
        chk("lat_valid",    32'(out_valid), 32'd1);
        chk("lat_data",     32'(out_data),  32'd60);
        send("L", 1'b0);
        send("L", 1'b0);
        send("O", 1'b1);
        idle();
        expect_out("hello_H", 8'd60, 1'b0, 1'b0);
        expect_out("hello_E", 8'd26, 1'b0, 1'b0);
        expect_out("hello_L1", 8'd55, 1'b0, 1'b0);
        expect_out("hello_L2", 8'd46, 1'b0, 1'b0);
        expect_out("hello_O", 8'd74, 1'b1, 1'b0);

        // Eight 'A': key wraps after seven characters
        repeat (8) send("A", 1'b0);
        idle();
        expect_out("wrap_0", 8'd47, 1'b0, 1'b0);
        expect_out("wrap_1", 8'd25, 1'b0, 1'b0);
        expect_out("wrap_2", 8'd34, 1'b0, 1'b0);
        expect_out("wrap_3", 8'd25, 1'b0, 1'b0);
        expect_out("wrap_4", 8'd45, 1'b0, 1'b0);
        expect_out("wrap_5", 8'd33, 1'b0, 1'b0);
        expect_out("wrap_6", 8'd57, 1'b0, 1'b0);
        expect_out("wrap_7", 8'd47, 1'b0, 1'b0);

        // Reset returns k to 0 (k was 1 here)
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // "AB" (last on B) then "A": message boundary resets k
        send("A", 1'b0);
        send("B", 1'b1);
        send("A", 1'b1);
        idle();
        expect_out("ab_A", 8'd47, 1'b0, 1'b0);
        expect_out("ab_B", 8'd28, 1'b1, 1'b0);
        expect_out("next_A", 8'd47, 1'b1, 1'b0);

        // "J1" then 'A': J encodes as I, '1' is an error but k still advances
        send("J", 1'b0);
        send("1", 1'b0);
        send("A", 1'b1);
        idle();
        expect_out("j_as_i", 8'd66, 1'b0, 1'b0);
        expect_out("err_1", 8'd0, 1'b0, 1'b1);
        expect_out("k_after_err", 8'd34, 1'b1, 1'b0);

        // Stall: out_ready low, two characters fill the pipeline
        out_ready = 1'b0;
        send("A", 1'b0);
        send("A", 1'b0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_valid",    32'(out_valid), 32'd1);
        fork
            begin
                send("A", 1'b0);
                send("A", 1'b1);
                idle();
            end
            begin
                logic stable;
                stable = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if (out_data !== 8'd47 || out_valid !== 1'b1 || in_ready !== 1'b0)
                        stable = 1'b0;
                end
                chk("stall_stable", 32'(stable), 32'd1);
                out_ready = 1'b1;
            end
        join
        expect_out("stall_0", 8'd47, 1'b0, 1'b0);
        expect_out("stall_1", 8'd25, 1'b0, 1'b0);
        expect_out("stall_2", 8'd34, 1'b0, 1'b0);
        expect_out("stall_3", 8'd25, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("stall_no_dup", 32'(r_q.size()), 32'd0);

        // Mid-stream reset: output drops asynchronously, nothing survives
        send("A", 1'b0);
        send("A", 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r_q.delete();
        send("A", 1'b1);
        idle();
        expect_out("post_rst_A", 8'd47, 1'b1, 1'b0);
        send("a", 1'b1);
        idle();
`ifdef NIHILIST_LOWERCASE_EN
        expect_out("lower_a", 8'd47, 1'b1, 1'b0);
`else
        expect_out("lower_a", 8'd0, 1'b1, 1'b1);
`endif
        repeat (3) @(negedge clk);
        chk("end_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
